// File: rtl/full_adder_pkg.sv
// Shared types and the single-bit add equation used by every adder cell.
// Keeps the carry/sum logic in one place so cells and models agree.
package full_adder_pkg;

    localparam int unsigned FA_MAX_WIDTH = 64;

    typedef struct packed {
        logic c;
        logic s;
    } fa_bit_t;

    function automatic fa_bit_t fa_eval(
        input logic a,
        input logic b,
        input logic ci
    );
        fa_bit_t r;
        r.s = a ^ b ^ ci;
        r.c = (a & b) | (ci & (a ^ b));
        return r;
    endfunction

endpackage

// File: rtl/full_adder_cell.sv
// One-bit full adder cell; plain gate equations so X/Z propagate.
module full_adder_cell
    import full_adder_pkg::*;
(
    input  logic a,
    input  logic b,
    input  logic cin,
    output logic s,
    output logic c
);

    fa_bit_t w_res;

    assign w_res = fa_eval(a, b, cin);
    assign s     = w_res.s;
    assign c     = w_res.c;

endmodule

// File: rtl/full_adder.sv
// WIDTH-bit ripple-carry adder with combinational result and an
// optional one-cycle registered copy qualified by in_valid.
module full_adder
    import full_adder_pkg::*;
#(
    parameter int unsigned WIDTH   = 1,
    parameter bit          REG_OUT = 1'b1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
    input  logic             in_valid,
    output logic [WIDTH-1:0] s,
    output logic             c,
    output logic [WIDTH-1:0] s_r,
    output logic             c_r,
    output logic             out_valid
);

    logic [WIDTH:0]   w_carry;
    logic [WIDTH-1:0] w_sum;

    assign w_carry[0] = cin;

    for (genvar i = 0; i < WIDTH; i++) begin : g_cell
        full_adder_cell u_cell (
            .a   (a[i]),
            .b   (b[i]),
            .cin (w_carry[i]),
            .s   (w_sum[i]),
            .c   (w_carry[i+1])
        );
    end

    assign s = w_sum;
    assign c = w_carry[WIDTH];

    if (REG_OUT) begin : g_reg
        logic [WIDTH-1:0] r_s;
        logic             r_c;
        logic             r_v;

        // Reset drops the in-flight sample; idle cycles hold the last result.
        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
                r_s <= '0;
                r_c <= 1'b0;
                r_v <= 1'b0;
            end else begin
                r_v <= in_valid;
                if (in_valid) begin
                    r_s <= w_sum;
                    r_c <= w_carry[WIDTH];
                end
            end
        end

        assign s_r       = r_s;
        assign c_r       = r_c;
        assign out_valid = r_v;
    end else begin : g_noreg
        assign s_r       = '0;
        assign c_r       = 1'b0;
        assign out_valid = 1'b0;
    end

endmodule

// File: tb/tb_full_adder.sv
// Directed + randomized bench for full_adder at WIDTH 1, 4, 8 and REG_OUT=0.
module tb_full_adder;

    logic clk = 1'b0;
    logic rst_n = 1'b0;

    always #5 clk = ~clk;

    logic       a1, b1, ci1, v1;
    logic       s1, c1, sr1, cr1, ov1;
    logic [3:0] a4, b4, s4, sr4;
    logic       ci4, v4, c4, cr4, ov4;
    logic [7:0] a8, b8, s8, sr8, s0, sr0;
    logic       ci8, v8, c8, cr8, ov8, c0, cr0, ov0;

    int checks = 0;
    int errors = 0;

    full_adder #(.WIDTH(1), .REG_OUT(1'b1)) u_w1 (
        .clk(clk), .rst_n(rst_n), .a(a1), .b(b1), .cin(ci1),
        .in_valid(v1), .s(s1), .c(c1), .s_r(sr1), .c_r(cr1),
        .out_valid(ov1));

    full_adder #(.WIDTH(4), .REG_OUT(1'b1)) u_w4 (
        .clk(clk), .rst_n(rst_n), .a(a4), .b(b4), .cin(ci4),
        .in_valid(v4), .s(s4), .c(c4), .s_r(sr4), .c_r(cr4),
        .out_valid(ov4));

    full_adder #(.WIDTH(8), .REG_OUT(1'b1)) u_w8 (
        .clk(clk), .rst_n(rst_n), .a(a8), .b(b8), .cin(ci8),
        .in_valid(v8), .s(s8), .c(c8), .s_r(sr8), .c_r(cr8),
        .out_valid(ov8));

    full_adder #(.WIDTH(8), .REG_OUT(1'b0)) u_w8n (
        .clk(clk), .rst_n(rst_n), .a(a8), .b(b8), .cin(ci8),
        .in_valid(v8), .s(s0), .c(c0), .s_r(sr0), .c_r(cr0),
        .out_valid(ov0));

    task automatic chk(input string tag, input logic [63:0] obs,
                       input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    initial begin
        #200000;
        $display("FAIL timeout");
        $fatal(1, "timeout");
    end

    initial begin
        int unsigned sum;
        logic [8:0]  exp_r;
        logic        exp_ov;

        a1 = 0; b1 = 0; ci1 = 0; v1 = 0;
        a4 = 0; b4 = 0; ci4 = 0; v4 = 0;
        a8 = 0; b8 = 0; ci8 = 0; v8 = 0;

        #1;
        chk("reset_w1", {61'd0, ov1, cr1, sr1}, 64'd0);
        chk("reset_w8", {55'd0, ov8, cr8, sr8}, 64'd0);
        chk("reset_noreg", {55'd0, ov0, cr0, sr0}, 64'd0);

        // Exhaustive one-bit truth table; reset still asserted.
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            {a1, b1, ci1} = 3'(i);
            v1 = 1'b1;
            #1;
            sum = 32'(a1) + 32'(b1) + 32'(ci1);
            chk($sformatf("tt_%0d", i), {62'd0, c1, s1}, 64'(sum));
            chk($sformatf("tt_rst_%0d", i), {61'd0, ov1, cr1, sr1}, 64'd0);
        end

        @(negedge clk);
        v1 = 1'b0;
        rst_n = 1'b1;

        // Single registered sample at WIDTH=1.
        @(negedge clk);
        a1 = 1; b1 = 1; ci1 = 0; v1 = 1;
        @(posedge clk);
        #1;
        chk("w1_reg_sr", 64'(sr1), 64'd0);
        chk("w1_reg_cr", 64'(cr1), 64'd1);
        chk("w1_reg_ov", 64'(ov1), 64'd1);
        v1 = 0; a1 = 0; b1 = 0;
        @(posedge clk);
        #1;
        chk("w1_hold_ov", 64'(ov1), 64'd0);
        chk("w1_hold_sc", {62'd0, cr1, sr1}, 64'd2);

        // WIDTH=4 boundaries.
        @(negedge clk);
        a4 = 4'hF; b4 = 4'h1; ci4 = 1;
        #1;
        chk("w4_wrap", {59'd0, c4, s4}, {59'd0, 1'b1, 4'h1});
        a4 = 0; b4 = 0; ci4 = 0;
        #1;
        chk("w4_zero", {59'd0, c4, s4}, 64'd0);
        a4 = 4'hF; b4 = 4'hF; ci4 = 1;
        #1;
        chk("w4_max", {59'd0, c4, s4}, {59'd0, 1'b1, 4'hF});

        // Randomized WIDTH=8 against arithmetic model.
        exp_r = '0;
        exp_ov = 1'b0;
        for (int n = 0; n < 1000; n++) begin
            @(negedge clk);
            a8 = 8'($urandom);
            b8 = 8'($urandom);
            ci8 = 1'($urandom);
            v8 = ($urandom_range(0, 3) != 0);
            #1;
            sum = 32'(a8) + 32'(b8) + 32'(ci8);
            chk("w8_comb", {55'd0, c8, s8}, 64'(sum));
            @(posedge clk);
            if (v8) exp_r = 9'(sum);
            exp_ov = v8;
            #1;
            chk("w8_reg", {55'd0, ov8, cr8, sr8}, {55'd0, exp_ov, exp_r});
            chk("noreg_zero", {55'd0, ov0, cr0, sr0}, 64'd0);
        end

        @(negedge clk);
        a8 = 8'hFF; b8 = 8'hFF; ci8 = 1; v8 = 1;
        #1;
        chk("w8_max", {55'd0, c8, s8}, {55'd0, 1'b1, 8'hFF});

        // Capture a carry, then pulse reset while a valid sample is pending.
        @(negedge clk);
        a8 = 8'h80; b8 = 8'h80; ci8 = 0; v8 = 1;
        @(posedge clk);
        #1;
        chk("pre_rst", {55'd0, ov8, cr8, sr8}, {55'd0, 1'b1, 1'b1, 8'h00});
        a8 = 8'h12; b8 = 8'h34;
        #2;
        rst_n = 1'b0;
        #1;
        chk("rst_async", {55'd0, ov8, cr8, sr8}, 64'd0);
        @(posedge clk);
        #1;
        chk("rst_no_cap", {55'd0, ov8, cr8, sr8}, 64'd0);
        @(negedge clk);
        rst_n = 1'b1;
        a8 = 8'h03; b8 = 8'h04; ci8 = 0; v8 = 1;
        @(posedge clk);
        #1;
        chk("first_cap", {55'd0, ov8, cr8, sr8}, {55'd0, 1'b1, 1'b0, 8'h07});
        chk("comb_after_rst", {55'd0, c8, s8}, 64'd7);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
